// File: rtl/serv_bufreg_seq_if.sv
// Handshake and strobe bundle between the buffer-register sequencer and its user.
interface serv_bufreg_seq_if;
  logic       i_start;
  logic       i_wen;
  logic [1:0] i_size;
  logic [1:0] i_lsb;
  logic       i_dbus_ack;
  logic       o_en;
  logic       o_init;
  logic       o_cnt0;
  logic       o_cnt1;
  logic       o_dbus_cyc;
  logic       o_busy;
  logic       o_done;
  logic       o_trap;

  modport master (
    output i_start, i_wen, i_size, i_lsb, i_dbus_ack,
    input  o_en, o_init, o_cnt0, o_cnt1, o_dbus_cyc, o_busy, o_done, o_trap
  );

  modport slave (
    input  i_start, i_wen, i_size, i_lsb, i_dbus_ack,
    output o_en, o_init, o_cnt0, o_cnt1, o_dbus_cyc, o_busy, o_done, o_trap
  );
endinterface

// File: rtl/serv_bufreg_seq.sv
// Memory-op sequencer for the serial buffer register: INIT phase, bus wait, RUN phase, DONE.
// Optional misalignment trap enabled by defining SERV_BUFREG_SEQ_MISALIGN_EN.
module serv_bufreg_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  serv_bufreg_seq_if.slave io
);

  localparam int unsigned N  = 32 / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    BUS  = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wen_q, wen_d;
  logic          misaligned;

`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
  logic [1:0] size_q, size_d;
  logic       trap_q, trap_d;

  // 11 decodes as word, same as 10.
  assign misaligned = (size_q[1] & (|io.i_lsb)) |
                      ((size_q == 2'b01) & io.i_lsb[0]);
`else
  logic unused_c;
  assign unused_c   = ^{io.i_size, io.i_lsb};
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
      size_q  <= 2'b00;
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
      size_q  <= size_d;
      trap_q  <= trap_d;
`endif
    end
  end

  // Next-state logic; cnt wraps to 0 naturally since N is a power of two.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
    size_d  = size_q;
    trap_d  = trap_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io.i_start) begin
          state_d = INIT;
          cnt_d   = '0;
          wen_d   = io.i_wen;
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
          size_d  = io.i_size;
          trap_d  = 1'b0;
`endif
        end
      end
      INIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = misaligned ? DONE : BUS;
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
          trap_d  = misaligned;
`endif
        end
      end
      BUS: begin
        if (io.i_dbus_ack) begin
          state_d = wen_q ? DONE : RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from state and cnt only.
  assign io.o_en       = (state_q == INIT) | (state_q == RUN);
  assign io.o_init     = (state_q == INIT);
  assign io.o_cnt0     = io.o_en & (cnt_q == CW'(0));
  assign io.o_cnt1     = io.o_en & (cnt_q == CW'(1));
  assign io.o_dbus_cyc = (state_q == BUS);
  assign io.o_busy     = (state_q != IDLE);
  assign io.o_done     = (state_q == DONE);
`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
  assign io.o_trap     = (state_q == DONE) & trap_q;
`else
  assign io.o_trap     = 1'b0;
`endif

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// Drives a BITS_PER_CYCLE=1 and a BITS_PER_CYCLE=4 sequencer and compares every cycle
// against an expected-output trace built from the operation description.
module tb_serv_bufreg_seq;

  typedef logic [7:0] obs_t; // {en, init, cnt0, cnt1, dbus_cyc, busy, done, trap}

`ifdef SERV_BUFREG_SEQ_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serv_bufreg_seq_if ifa ();
  serv_bufreg_seq_if ifb ();

  serv_bufreg_seq #(.BITS_PER_CYCLE(1)) u_dut_a (.i_clk(clk), .i_rst(rst_a), .io(ifa.slave));
  serv_bufreg_seq #(.BITS_PER_CYCLE(4)) u_dut_b (.i_clk(clk), .i_rst(rst_b), .io(ifb.slave));

  obs_t obs_a, obs_b;
  assign obs_a = {ifa.o_en, ifa.o_init, ifa.o_cnt0, ifa.o_cnt1,
                  ifa.o_dbus_cyc, ifa.o_busy, ifa.o_done, ifa.o_trap};
  assign obs_b = {ifb.o_en, ifb.o_init, ifb.o_cnt0, ifb.o_cnt1,
                  ifb.o_dbus_cyc, ifb.o_busy, ifb.o_done, ifb.o_trap};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected per-cycle outputs, cycle 0 being the first INIT cycle.
  task automatic build(input int n, input bit wen, input logic [1:0] size, input logic [1:0] lsb,
                       input int delay, input bit rst_bus, output obs_t q[$], output int ack_idx);
    bit mis;
    q.delete();
    for (int i = 0; i < n; i++) q.push_back({1'b1, 1'b1, i == 0, i == 1, 4'b0100});
    mis = MIS_EN && ((size >= 2'd2 && lsb != 2'd0) || (size == 2'd1 && lsb[0]));
    ack_idx = -1;
    if (mis) begin
      q.push_back(8'b0000_0111);
      return;
    end
    ack_idx = n + delay;
    for (int i = 0; i <= delay; i++) q.push_back(8'b0000_1100);
    if (rst_bus) return;
    if (!wen) for (int i = 0; i < n; i++) q.push_back({1'b1, 1'b0, i == 0, i == 1, 4'b0100});
    q.push_back(8'b0000_0110);
  endtask

  task automatic run_txn(input string name, input bit wen, input logic [1:0] size,
                         input logic [1:0] lsb, input int delay, input bit rst_bus);
    obs_t qa[$], qb[$];
    int   ack_a, ack_b, tmax;
    build(32, wen, size, lsb, delay, rst_bus, qa, ack_a);
    build(8,  wen, size, lsb, delay, rst_bus, qb, ack_b);
    tmax = (qa.size() > qb.size()) ? qa.size() : qb.size();
    // Idle with stray acks: nothing may move.
    for (int i = 0; i < 2; i++) begin
      ifa.i_dbus_ack = 1'($urandom_range(1)); ifb.i_dbus_ack = 1'($urandom_range(1));
      @(posedge clk); #1;
      check_eq($sformatf("%s idle_a", name), 32'(obs_a), 32'h0);
      check_eq($sformatf("%s idle_b", name), 32'(obs_b), 32'h0);
    end
    ifa.i_start = 1'b1; ifa.i_wen = wen; ifa.i_size = size; ifa.i_lsb = lsb;
    ifb.i_start = 1'b1; ifb.i_wen = wen; ifb.i_size = size; ifb.i_lsb = lsb;
    @(posedge clk); #1;
    for (int t = 0; t <= tmax; t++) begin
      check_eq($sformatf("%s a t=%0d", name, t), 32'(obs_a), 32'(t < qa.size() ? qa[t] : 8'h0));
      check_eq($sformatf("%s b t=%0d", name, t), 32'(obs_b), 32'(t < qb.size() ? qb[t] : 8'h0));
      if (t == tmax) break;
      // Random starts while busy must be ignored; acks only matter in BUS.
      ifa.i_start = (t < qa.size()) ? 1'($urandom_range(1)) : 1'b0;
      ifb.i_start = (t < qb.size()) ? 1'($urandom_range(1)) : 1'b0;
      ifa.i_dbus_ack = (t == ack_a) ? 1'b1 : (ack_a >= 0 && t >= 32 && t < ack_a) ? 1'b0
                       : 1'($urandom_range(1));
      ifb.i_dbus_ack = (t == ack_b) ? 1'b1 : (ack_b >= 0 && t >= 8 && t < ack_b) ? 1'b0
                       : 1'($urandom_range(1));
      rst_a = rst_bus && (t == ack_a);
      rst_b = rst_bus && (t == ack_b);
      @(posedge clk); #1;
    end
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.i_start = 1'b0; ifb.i_start = 1'b0;
    ifa.i_dbus_ack = 1'b0; ifb.i_dbus_ack = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.i_start = 1'b0; ifa.i_wen = 1'b0; ifa.i_size = 2'b00; ifa.i_lsb = 2'b00; ifa.i_dbus_ack = 1'b0;
    ifb.i_start = 1'b0; ifb.i_wen = 1'b0; ifb.i_size = 2'b00; ifb.i_lsb = 2'b00; ifb.i_dbus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_a", 32'(obs_a), 32'h0);
    check_eq("reset_b", 32'(obs_b), 32'h0);
    rst_a = 1'b0; rst_b = 1'b0;

    run_txn("word_load",  1'b0, 2'b10, 2'b00, 2, 1'b0);
    run_txn("half_store", 1'b1, 2'b01, 2'b10, 0, 1'b0);
    run_txn("misalign_w", 1'b0, 2'b10, 2'b01, 1, 1'b0);
    run_txn("misalign_h", 1'b1, 2'b01, 2'b11, 0, 1'b0);
    run_txn("size11_ok",  1'b0, 2'b11, 2'b00, 4, 1'b0);
    run_txn("byte_odd",   1'b0, 2'b00, 2'b11, 1, 1'b0);
    run_txn("rst_in_bus", 1'b0, 2'b10, 2'b00, 3, 1'b1);
    run_txn("rst_bus_st", 1'b1, 2'b00, 2'b00, 0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      run_txn($sformatf("rnd%0d", k), 1'($urandom_range(1)), 2'($urandom_range(3)),
              2'($urandom_range(3)), int'($urandom_range(6)), ($urandom_range(7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
